// File: rtl/clk_freq_meter_if.sv
// clk_freq_meter_if: control/result bundle between a frequency-meter client and the meter.
interface clk_freq_meter_if #(
    parameter int CNT_W = 26
);
    logic             sig_in;
    logic             start;
    logic             continuous;
    logic             busy;
    logic [CNT_W-1:0] freq_out;
    logic             valid;
    logic             overflow;

    modport master (
        output sig_in, start, continuous,
        input  busy, freq_out, valid, overflow
    );

    modport slave (
        input  sig_in, start, continuous,
        output busy, freq_out, valid, overflow
    );
endinterface

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts synchronized rising edges of sig_in over a GATE_CYCLES window and
// publishes the count with a one-cycle valid strobe.
module clk_freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    clk_freq_meter_if.slave  bus
);
    localparam int GW = $clog2(GATE_CYCLES);

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]       freq_q, freq_d;
    logic                   sat_q, sat_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic                   rise, last_gate, go;

    assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign last_gate = gate_cnt_q == GW'(GATE_CYCLES - 1);
    assign go        = bus.start | bus.continuous;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            freq_q     <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (go ? GATE : IDLE) :
                  state_q == GATE ? (last_gate ? DONE : GATE) :
                  (bus.continuous ? GATE : IDLE);
    end

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
        prev_d     = sync_q[SYNC_STAGES-1];
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        // Every entry into GATE (from IDLE or straight from DONE) starts a fresh window.
        if (state_d == GATE && state_q != GATE) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end else if (state_q == GATE) begin
            gate_cnt_d = gate_cnt_q + 1'b1;
            if (rise) begin
                sat_d      = sat_q | (&edge_cnt_q);
                edge_cnt_d = &edge_cnt_q ? edge_cnt_q : edge_cnt_q + 1'b1;
            end
        end
        if (state_q == DONE) begin
            freq_d  = edge_cnt_q;
            ovf_d   = sat_q;
            valid_d = 1'b1;
        end
    end

    assign bus.busy     = state_q != IDLE;
    assign bus.freq_out = freq_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: directed vector table plus hand sequences for continuous mode, reset abort
// and window-boundary edges; dut_a uses CNT_W=26, dut_b CNT_W=4 for saturation.
module tb_clk_freq_meter;
    localparam int GC = 100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    clk_freq_meter_if #(.CNT_W(26)) ifa ();
    clk_freq_meter_if #(.CNT_W(4))  ifb ();

    logic sig_gen = 1'b0;
    logic sig_man = 1'b0;
    int   per = 0;
    int   ph = 0;

    assign ifa.sig_in = per > 0 ? sig_gen : sig_man;
    assign ifb.sig_in = per > 0 ? sig_gen : sig_man;

    clk_freq_meter #(.GATE_CYCLES(GC), .CNT_W(26), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    clk_freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    // Square wave with period 'per' clk cycles, high for the first half.
    always @(negedge clk) begin
        if (per > 0) begin
            ph = (ph + 1 >= per) ? 0 : ph + 1;
            sig_gen = ph < per / 2;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic vld(input int d);
        return d == 0 ? ifa.valid : ifb.valid;
    endfunction

    function automatic longint frq(input int d);
        return d == 0 ? longint'(ifa.freq_out) : longint'(ifb.freq_out);
    endfunction

    function automatic logic ovf(input int d);
        return d == 0 ? ifa.overflow : ifb.overflow;
    endfunction

    function automatic logic bsy(input int d);
        return d == 0 ? ifa.busy : ifb.busy;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) ifa.start = v;
        else ifb.start = v;
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!vld(d) && n < 300);
        chk("valid_seen", vld(d), 1);
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(d, 1'b0);
    endtask

    typedef struct {
        int     d;
        int     per;
        logic   lvl;
        longint f;
        logic   o;
    } vec_t;

    vec_t tv[8];

    initial begin
        int n, cnt;
        ifa.start = 1'b0; ifa.continuous = 1'b0;
        ifb.start = 1'b0; ifb.continuous = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_freq", ifa.freq_out, 0);
        chk("rst_valid", ifa.valid, 0);
        chk("rst_ovf", ifb.overflow, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        tv[0] = '{0, 10, 1'b0, 10, 1'b0};
        tv[1] = '{0, 20, 1'b0, 5,  1'b0};
        tv[2] = '{0, 4,  1'b0, 25, 1'b0};
        tv[3] = '{0, 0,  1'b0, 0,  1'b0};
        tv[4] = '{0, 0,  1'b1, 0,  1'b0};
        tv[5] = '{1, 2,  1'b0, 15, 1'b1};
        tv[6] = '{1, 10, 1'b0, 10, 1'b0};
        tv[7] = '{1, 4,  1'b0, 15, 1'b1};

        for (int i = 0; i < 8; i++) begin
            per = tv[i].per;
            sig_man = tv[i].lvl;
            repeat (20) @(negedge clk);
            pulse_start(tv[i].d);
            wait_valid(tv[i].d, n);
            chk($sformatf("v%0d_latency", i), n, GC + 1);
            chk($sformatf("v%0d_freq", i), frq(tv[i].d), tv[i].f);
            chk($sformatf("v%0d_ovf", i), ovf(tv[i].d), tv[i].o);
            chk($sformatf("v%0d_busy_after", i), bsy(tv[i].d), 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_width", i), vld(tv[i].d), 0);
        end

        // Continuous mode: back-to-back windows, then one more result after dropping it.
        per = 20;
        repeat (20) @(negedge clk);
        ifa.continuous = 1'b1;
        wait_valid(0, n);
        chk("cont_freq0", ifa.freq_out, 5);
        wait_valid(0, n);
        chk("cont_period", n, GC + 1);
        chk("cont_freq1", ifa.freq_out, 5);
        chk("cont_busy_mid", ifa.busy, 1);
        @(negedge clk);
        ifa.continuous = 1'b0;
        wait_valid(0, n);
        chk("cont_last_period", n, GC + 1);
        chk("cont_last_freq", ifa.freq_out, 5);
        chk("cont_busy_end", ifa.busy, 0);
        cnt = 0;
        repeat (150) begin @(posedge clk); #1; if (ifa.valid || ifa.busy) cnt++; end
        chk("cont_quiet", cnt, 0);

        // start pulsed during GATE must not extend or add a window.
        per = 10;
        repeat (20) @(negedge clk);
        pulse_start(0);
        repeat (30) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_valid(0, n);
        chk("busy_start_latency", n, 70);
        chk("busy_start_freq", ifa.freq_out, 10);
        cnt = 0;
        repeat (150) begin @(posedge clk); #1; if (ifa.valid || ifa.busy) cnt++; end
        chk("busy_start_quiet", cnt, 0);

        // Reset at cycle 50 of a window aborts it.
        pulse_start(0);
        repeat (49) @(negedge clk);
        chk("pre_reset_busy", ifa.busy, 1);
        reset = 1'b0;
        #1;
        chk("reset_busy", ifa.busy, 0);
        chk("reset_freq", ifa.freq_out, 0);
        chk("reset_valid", ifa.valid, 0);
        chk("reset_freq_b", ifb.freq_out, 0);
        chk("reset_ovf_b", ifb.overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (200) begin @(posedge clk); #1; if (ifa.valid || ifa.busy) cnt++; end
        chk("reset_quiet", cnt, 0);
        chk("reset_freq_hold", ifa.freq_out, 0);

        // Single edge whose rise lands on the last GATE cycle: counted.
        per = 0;
        sig_man = 1'b0;
        repeat (20) @(negedge clk);
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.start = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 97) sig_man = 1'b1;
        end while (!ifa.valid && n < 300);
        chk("edge_last_latency", n, GC + 1);
        chk("edge_last_freq", ifa.freq_out, 1);

        // Single edge whose rise lands on the DONE cycle: dropped from both windows.
        sig_man = 1'b0;
        repeat (20) @(negedge clk);
        @(negedge clk);
        ifa.continuous = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 98) sig_man = 1'b1;
        end while (!ifa.valid && n < 300);
        chk("edge_done_latency", n, GC + 1);
        chk("edge_done_freq0", ifa.freq_out, 0);
        @(negedge clk);
        ifa.continuous = 1'b0;
        wait_valid(0, n);
        chk("edge_done_freq1", ifa.freq_out, 0);
        chk("edge_done_ovf", ifa.overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
